// File: rtl/fetch_ctrl_if.sv
// Control bundle between fetch_ctrl and the PC loader / inst cache / IF_ID.
// The master side is the controller; the slave side is its environment.
interface fetch_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             branchTaken;
  logic             hazardIn;
  logic             icacheValid;
  logic             lockerOut;
  logic             flushOut;
  logic             pcHold;
  logic             pcRedirect;
  logic             fetchCancel;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  modport master (
    input  branchTaken, hazardIn, icacheValid,
    output lockerOut, flushOut, pcHold, pcRedirect, fetchCancel, stallCnt, flushCnt
  );

  modport slave (
    output branchTaken, hazardIn, icacheValid,
    input  lockerOut, flushOut, pcHold, pcRedirect, fetchCancel, stallCnt, flushCnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch/decode boundary controller: arbitrates branch flush, load-use stall and
// inst-cache miss, drives IF_ID / PC loader controls and counts lost cycles.
module fetch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input logic          clk,
  input logic          resetN,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {StRun, StFlush, StMiss} state_e;

  localparam logic [3:0] FlushReload = 4'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       flush_left_q, flush_left_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             locker, flush, hold, redirect, cancel;

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    locker       = 1'b0;
    flush        = 1'b0;
    hold         = 1'b0;
    redirect     = 1'b0;
    cancel       = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.branchTaken) begin
          redirect  = 1'b1;
          flush     = 1'b1;
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d      = StFlush;
            flush_left_d = FlushReload;
          end
        end else if (bus.hazardIn) begin
          hold      = 1'b1;
          stall_inc = 1'b1;
        end else if (!bus.icacheValid) begin
          hold      = 1'b1;
          flush     = 1'b1;
          stall_inc = 1'b1;
          state_d   = StMiss;
        end else begin
          locker = 1'b1;
        end
      end
      StFlush: begin
        // Hazard and miss are don't-care here: the fetched slots become bubbles.
        flush     = 1'b1;
        flush_inc = 1'b1;
        if (bus.branchTaken) begin
          redirect = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_left_d = FlushReload;
          end else begin
            state_d      = StRun;
            flush_left_d = 4'd0;
          end
        end else if (flush_left_q <= 4'd1) begin
          state_d      = StRun;
          flush_left_d = 4'd0;
        end else begin
          flush_left_d = flush_left_q - 4'd1;
        end
      end
      StMiss: begin
        if (bus.branchTaken) begin
          cancel    = 1'b1;
          redirect  = 1'b1;
          flush     = 1'b1;
          flush_inc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d      = StFlush;
            flush_left_d = FlushReload;
          end else begin
            state_d = StRun;
          end
        end else if (bus.icacheValid && !bus.hazardIn) begin
          locker  = 1'b1;
          state_d = StRun;
        end else if (bus.icacheValid) begin
          // Hit arrives under a hazard: hold PC so the line is re-read next cycle.
          hold      = 1'b1;
          stall_inc = 1'b1;
          state_d   = StRun;
        end else begin
          hold      = 1'b1;
          flush     = 1'b1;
          stall_inc = 1'b1;
        end
      end
      default: begin
        state_d      = StRun;
        flush_left_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StRun;
      flush_left_q <= 4'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Reset overrides the decode so the pipeline sits on a held PC and a bubble.
  assign bus.lockerOut   = resetN & locker;
  assign bus.flushOut    = ~resetN | flush;
  assign bus.pcHold      = ~resetN | hold;
  assign bus.pcRedirect  = resetN & redirect;
  assign bus.fetchCancel = resetN & cancel;
  assign bus.stallCnt    = stall_cnt_q;
  assign bus.flushCnt    = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a FLUSH_CYCLES=2 instance run from a
// vector table, plus a FLUSH_CYCLES=1 / narrow-counter instance for wrap cases.
module tb_fetch_ctrl;

  typedef struct {
    logic        b;
    logic        h;
    logic        v;
    logic [4:0]  ctl;  // {lockerOut, flushOut, pcHold, pcRedirect, fetchCancel}
    logic [31:0] sc;
    logic [31:0] fc;
  } vec_t;

  localparam logic [4:0] CtlLk  = 5'b10000;
  localparam logic [4:0] CtlFl  = 5'b01000;
  localparam logic [4:0] CtlHz  = 5'b00100;
  localparam logic [4:0] CtlMs  = 5'b01100;
  localparam logic [4:0] CtlRst = 5'b01100;
  localparam logic [4:0] CtlBr  = 5'b01010;
  localparam logic [4:0] CtlCan = 5'b01011;

  logic clk = 1'b0;
  logic resetN;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t exp_q[$];
  vec_t tbl[29];

  fetch_ctrl_if #(.CNT_W(32)) ifm ();
  fetch_ctrl_if #(.CNT_W(3))  if2 ();

  fetch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (.clk(clk), .resetN(resetN), .bus(ifm));
  fetch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(3))  dut2 (.clk(clk), .resetN(resetN), .bus(if2));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic b, logic h, logic v, logic [4:0] ctl, int sc, int fc);
    vec_t r;
    r.b = b; r.h = h; r.v = v; r.ctl = ctl; r.sc = 32'(sc); r.fc = 32'(fc);
    return r;
  endfunction

  task automatic drive_main(input vec_t e);
    ifm.branchTaken = e.b;
    ifm.hazardIn    = e.h;
    ifm.icacheValid = e.v;
    exp_q.push_back(e);
  endtask

  task automatic drive_two(input vec_t e);
    if2.branchTaken = e.b;
    if2.hazardIn    = e.h;
    if2.icacheValid = e.v;
    exp_q.push_back(e);
  endtask

  task automatic compare(input string tag, input logic [4:0] ctl, input logic [31:0] sc,
                         input logic [31:0] fc);
    vec_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    if (ctl !== e.ctl) begin
      n_fail++;
      $display("FAIL %s ctl {lk,fl,hold,redir,cancel}: got %b want %b", tag, ctl, e.ctl);
    end
    n_checks++;
    if (sc !== e.sc) begin
      n_fail++;
      $display("FAIL %s stallCnt: got %0d want %0d", tag, sc, e.sc);
    end
    n_checks++;
    if (fc !== e.fc) begin
      n_fail++;
      $display("FAIL %s flushCnt: got %0d want %0d", tag, fc, e.fc);
    end
    n_checks++;
    if ((ctl[4] && ctl[3]) || (ctl[2] && ctl[1])) begin
      n_fail++;
      $display("FAIL %s invariant: ctl %b has locker+flush or hold+redirect", tag, ctl);
    end
  endtask

  task automatic check_main(input string tag);
    compare(tag, {ifm.lockerOut, ifm.flushOut, ifm.pcHold, ifm.pcRedirect, ifm.fetchCancel},
            ifm.stallCnt, ifm.flushCnt);
  endtask

  task automatic check_two(input string tag);
    compare(tag, {if2.lockerOut, if2.flushOut, if2.pcHold, if2.pcRedirect, if2.fetchCancel},
            {29'd0, if2.stallCnt}, {29'd0, if2.flushCnt});
  endtask

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = mk(0, 0, 1, CtlLk, 0, 0);
    tbl[5]  = mk(1, 0, 1, CtlBr,  0, 0);
    tbl[6]  = mk(0, 0, 1, CtlFl,  0, 1);
    tbl[7]  = mk(0, 0, 1, CtlLk,  0, 2);
    tbl[8]  = mk(0, 1, 1, CtlHz,  0, 2);
    tbl[9]  = mk(0, 1, 1, CtlHz,  1, 2);
    tbl[10] = mk(0, 1, 1, CtlHz,  2, 2);
    tbl[11] = mk(0, 0, 1, CtlLk,  3, 2);
    tbl[12] = mk(0, 0, 0, CtlMs,  3, 2);
    tbl[13] = mk(0, 0, 0, CtlMs,  4, 2);
    tbl[14] = mk(0, 0, 0, CtlMs,  5, 2);
    tbl[15] = mk(0, 0, 0, CtlMs,  6, 2);
    tbl[16] = mk(0, 0, 1, CtlLk,  7, 2);
    tbl[17] = mk(0, 0, 1, CtlLk,  7, 2);
    tbl[18] = mk(0, 0, 0, CtlMs,  7, 2);
    tbl[19] = mk(1, 0, 0, CtlCan, 8, 2);
    tbl[20] = mk(0, 1, 0, CtlFl,  8, 3);
    tbl[21] = mk(0, 0, 1, CtlLk,  8, 4);
    tbl[22] = mk(0, 0, 0, CtlMs,  8, 4);
    tbl[23] = mk(0, 1, 1, CtlHz,  9, 4);
    tbl[24] = mk(0, 0, 1, CtlLk, 10, 4);
    tbl[25] = mk(1, 0, 1, CtlBr, 10, 4);
    tbl[26] = mk(1, 0, 1, CtlBr, 10, 5);
    tbl[27] = mk(0, 0, 1, CtlFl, 10, 6);
    tbl[28] = mk(0, 0, 1, CtlLk, 10, 7);

    resetN = 1'b0;
    ifm.branchTaken = 1'b0; ifm.hazardIn = 1'b0; ifm.icacheValid = 1'b1;
    if2.branchTaken = 1'b0; if2.hazardIn = 1'b0; if2.icacheValid = 1'b1;
    #2;
    exp_q.push_back(mk(0, 0, 1, CtlRst, 0, 0));
    check_main("reset_main");
    exp_q.push_back(mk(0, 0, 1, CtlRst, 0, 0));
    check_two("reset_two");
    #10 resetN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 29; i++) begin
      drive_main(tbl[i]);
      @(negedge clk);
      check_main($sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Narrow instance, FLUSH_CYCLES=1: back-to-back branches stay in RUN and flushCnt wraps.
    ifm.branchTaken = 1'b0; ifm.hazardIn = 1'b0; ifm.icacheValid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_two(mk(1, 0, 1, CtlBr, 0, i % 8));
      @(negedge clk);
      check_two($sformatf("f1_branch%0d", i));
      @(posedge clk); #1;
    end
    drive_two(mk(0, 0, 1, CtlLk, 0, 1));
    @(negedge clk); check_two("f1_wrap_run"); @(posedge clk); #1;
    drive_two(mk(0, 0, 0, CtlMs, 0, 1));
    @(negedge clk); check_two("f1_miss"); @(posedge clk); #1;
    drive_two(mk(1, 0, 0, CtlCan, 1, 1));
    @(negedge clk); check_two("f1_miss_branch"); @(posedge clk); #1;
    drive_two(mk(0, 0, 1, CtlLk, 1, 2));
    @(negedge clk); check_two("f1_back_to_run"); @(posedge clk); #1;

    // Branch beats a simultaneous hazard, then reset lands mid-FLUSH.
    drive_main(mk(1, 1, 1, CtlBr, 10, 7));
    @(negedge clk); check_main("br_vs_hazard"); @(posedge clk); #1;
    drive_main(mk(0, 0, 1, CtlFl, 10, 8));
    #2 check_main("in_flush");
    resetN = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 1, CtlRst, 0, 0));
    check_main("reset_mid_flush");
    exp_q.push_back(mk(0, 0, 1, CtlRst, 0, 0));
    check_two("reset_two_counters");
    @(posedge clk); #2 resetN = 1'b1;
    @(posedge clk); #1;
    drive_main(mk(0, 0, 1, CtlLk, 0, 0));
    @(negedge clk); check_main("after_reset_run"); @(posedge clk); #1;

    // Reset while in MISS with a branch pending must not emit fetchCancel.
    drive_main(mk(0, 0, 0, CtlMs, 0, 0));
    @(negedge clk); check_main("enter_miss"); @(posedge clk); #1;
    ifm.branchTaken = 1'b1;
    resetN = 1'b0;
    #1;
    exp_q.push_back(mk(1, 0, 0, CtlRst, 0, 0));
    check_main("reset_mid_miss");
    @(posedge clk); #2 resetN = 1'b1;
    ifm.branchTaken = 1'b0; ifm.icacheValid = 1'b1;
    @(posedge clk); #1;
    drive_main(mk(0, 0, 1, CtlLk, 0, 0));
    @(negedge clk); check_main("after_miss_reset"); @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
